// File: rtl/adder_arb_sched.sv
// Round-robin scheduler sharing one registered prefix adder among NREQ requesters.
// Optional per-requester grant counters are built when ADDER_ARB_STATS_EN is defined.
module adder_arb_sched #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDER_LAT = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_cin,
  input  logic                    hold,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  output logic                    add_cin,
  input  logic [WIDTH-1:0]        add_sum,
  input  logic                    add_cout,
  output logic [NREQ-1:0]         resp_valid,
  output logic [WIDTH-1:0]        resp_sum,
  output logic                    resp_cout,
  output logic                    halted,
  output logic [NREQ*CNT_W-1:0]   grant_cnt
);

  localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PIPE_D = ADDER_LAT + 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  grant_idx;
  logic              found;
  logic              accept;
  logic              pipe_busy;
  logic [WIDTH-1:0]  sel_a, sel_b;
  logic              sel_cin;
  logic [PIPE_D-1:0] tag_v;
  logic [IDX_W-1:0]  tag_id [PIPE_D];

  // Rotating priority: indices above last first, then wrap to the low indices.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (IDX_W'(i) > last)) begin
        found     = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (IDX_W'(i) <= last)) begin
        found     = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (found && (state == RUN) && !hold) begin
      req_ready = NREQ'(1) << grant_idx;
    end
  end

  assign accept = |req_ready;

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
        sel_cin = req_cin[i];
      end
    end
  end

  // Busy covers the tag pipe and the response register.
  assign pipe_busy = (|tag_v) || (|resp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      RUN: begin
        if (hold) state_n = pipe_busy ? DRAIN : HALTED;
      end
      DRAIN: begin
        if (!hold)          state_n = RUN;
        else if (!pipe_busy) state_n = HALTED;
      end
      HALTED: begin
        if (!hold) state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  // Operand launch, tag pipeline aligned to adder latency, response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      last       <= IDX_W'(NREQ - 1);
      add_a      <= '0;
      add_b      <= '0;
      add_cin    <= 1'b0;
      tag_v      <= '0;
      for (int unsigned s = 0; s < PIPE_D; s++) tag_id[s] <= '0;
      resp_valid <= '0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
      halted     <= 1'b0;
    end else begin
      halted <= (state_n == HALTED);
      if (accept) begin
        last    <= grant_idx;
        add_a   <= sel_a;
        add_b   <= sel_b;
        add_cin <= sel_cin;
      end
      tag_v[0]  <= accept;
      tag_id[0] <= grant_idx;
      for (int unsigned s = 1; s < PIPE_D; s++) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
      resp_valid <= tag_v[PIPE_D-1] ? (NREQ'(1) << tag_id[PIPE_D-1]) : '0;
      if (tag_v[PIPE_D-1]) begin
        resp_sum  <= add_sum;
        resp_cout <= add_cout;
      end
    end
  end

`ifdef ADDER_ARB_STATS_EN
  logic [CNT_W-1:0] cnt [NREQ];

  // Saturating per-requester grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (accept && (grant_idx == IDX_W'(i)) && (cnt[i] != '1)) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule
